eu_xbuf_mp: RTL and testbench
=============================

Name: eu_xbuf_mp

Overview:
- Multi-read-port operand exchange buffer for an execution unit.
- Fully associative: DEPTH entries, each tagged by exec-unit address.
- Entries are written once from the interconnect/ALU result side and read by NUM_RD_PORTS consumers. Each entry carries a remaining-reads count and frees itself after its last consumer reads it.
- Replaces the single-consumer has-been-read scheme with a multi-consumer scheme. Adds occupancy status outputs.

Parameters:
- IDX_BITS, 2, DEPTH = 2**IDX_BITS entries.
- NUM_RD_PORTS, 2, number of independent read/request ports.
- CNT_WIDTH, 2, width of the per-entry remaining-reads counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_addr_i  in  $bits(type_exec_unit_addr)  tag of the entry being written.
- in_data_i  in  $bits(type_exec_unit_data)  operand data.
- in_cnt_i  in  CNT_WIDTH  number of consumers; a value of 0 is treated as 1.
- in_valid_i  in  1  write request.
- in_ready_o  out  1  write accepted this cycle when in_valid_i is also high.
- req_addr_i  in  NUM_RD_PORTS*$bits(type_exec_unit_addr)  per-port request tag.
- req_valid_i  in  NUM_RD_PORTS  per-port request valid.
- resp_data_o  out  NUM_RD_PORTS*$bits(type_exec_unit_data)  per-port registered response data.
- resp_success_o  out  NUM_RD_PORTS  per-port registered hit flag.
- occupancy_o  out  IDX_BITS+1  number of valid entries.
- full_o  out  1  occupancy_o == DEPTH.
- empty_o  out  1  occupancy_o == 0.

Behaviour:
- Entry state: valid, tag, data, cnt. On reset, all valid flags are 0. Reset outputs: resp_success_o=0, resp_data_o=0, occupancy_o=0, empty_o=1, full_o=0. Reset asserted mid-operation discards all entries and in-flight responses on the next edge.
- Write:
  - in_ready_o = ~full_o & ~dup, where dup is high if in_addr_i matches the tag of any valid entry. in_ready_o is combinational and may depend on in_valid_i/in_addr_i.
  - On accept, allocate the lowest-index free slot and store tag, data, and cnt = max(in_cnt_i,1).
  - The entry becomes visible to lookups the following cycle.
- Read:
  - Each port looks up its req_addr_i against all valid entries combinationally, in the cycle the request is presented.
  - A hit registers resp_success_o[p]=1 and resp_data_o[p]=entry data, visible one cycle after the request.
  - A miss registers resp_success_o[p]=0; resp_data_o[p] holds its previous value.
  - No retry state is kept; a requester must re-present a missed request.
- Consume:
  - Each cycle, cnt of an entry decrements by k = number of ports hitting it that cycle.
  - If k >= cnt, all k ports still succeed, and the entry is freed at the clock edge (valid=0).
- Simultaneous events:
  - A slot freed this cycle is not reallocated until the next cycle; allocation uses pre-edge state.
  - A write and a free in the same cycle leave occupancy unchanged.
  - A write tag equal to a tag being freed this cycle is rejected as dup.
- occupancy_o is registered: +1 on accept, -1 per freed entry; multiple frees in one cycle are possible.
- Duplicate tags never coexist.
- Full: in_ready_o=0. Reads still proceed, and a read that frees an entry enables a write on the next cycle.

Optional Feature:
- EU_XBUF_MP_BYPASS_EN, when defined: a valid request whose tag matches in_addr_i of a write accepted this cycle hits via bypass.
  - The response arrives next cycle with in_data_i.
  - The stored cnt is max(in_cnt_i,1) minus the bypass hits.
  - If the stored cnt would be <= 0, the entry is not allocated and occupancy is unchanged.
  - in_ready_o is unaffected by bypass.
- When undefined: same-cycle requests to a write being accepted miss.

Test Plan:
- Reset, then write addr=5, data=0xAB, cnt=1. Next cycle port0 requests 5 -> cycle after: resp_success_o[0]=1, data 0xAB; occupancy 1->0, empty_o=1.
- Write addr=3, cnt=2. Port0 and port1 both request 3 in the same cycle -> both succeed with the same data; entry freed; occupancy returns to 0.
- Fill DEPTH=4 entries (addrs 1..4, cnt=1) -> full_o=1, in_ready_o=0 for addr 7. Read addr 2 -> next cycle in_ready_o=1; write 7 lands in slot 1.
- Write addr=6 while valid entry 6 exists -> in_ready_o=0, no state change. Request addr=9 (absent) -> resp_success_o=0, resp_data_o unchanged.
- Same cycle: accept write addr=8 and port0 requests 8. Without EU_XBUF_MP_BYPASS_EN -> miss; with it -> hit, data correct; cnt=1 entry not allocated.
- Assert reset while 3 entries are valid and a request is outstanding -> next cycle resp_success_o=0, occupancy_o=0; a subsequent read of an old tag misses.

Source files
------------

// File: rtl/eu_xbuf_mp.sv
// eu_xbuf_mp: fully associative multi-consumer operand exchange buffer with occupancy status.
// Optional same-cycle write-to-read bypass enabled by defining EU_XBUF_MP_BYPASS_EN.
module eu_xbuf_mp #(
    parameter int IDX_BITS     = 2,
    parameter int NUM_RD_PORTS = 2,
    parameter int CNT_WIDTH    = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_WIDTH-1:0]              in_addr_i,
    input  logic [DATA_WIDTH-1:0]              in_data_i,
    input  logic [CNT_WIDTH-1:0]               in_cnt_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_RD_PORTS-1:0]            req_valid_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] resp_data_o,
    output logic [NUM_RD_PORTS-1:0]            resp_success_o,
    output logic [IDX_BITS:0]                  occupancy_o,
    output logic                               full_o,
    output logic                               empty_o
);
    localparam int DEPTH = 2**IDX_BITS;
    // wide enough to hold both a per-cycle hit count and a stored count without wrap
    localparam int KW = $clog2(NUM_RD_PORTS+1) + CNT_WIDTH;
    typedef logic [IDX_BITS:0] occ_t;
    logic [DEPTH-1:0]            valid;
    logic [ADDR_WIDTH-1:0]       tag      [DEPTH];
    logic [DATA_WIDTH-1:0]       data     [DEPTH];
    logic [CNT_WIDTH-1:0]        cnt      [DEPTH];
    logic [CNT_WIDTH-1:0]        cnt_next [DEPTH];
    logic [DATA_WIDTH-1:0]       hit_data [NUM_RD_PORTS];
    logic [DEPTH-1:0]            free_e;
    logic [NUM_RD_PORTS-1:0]     hit_p;
    logic [NUM_RD_PORTS-1:0]     byp;
    logic [KW-1:0]               k;
    logic [KW-1:0]               bk;
    logic [IDX_BITS-1:0]         slot;
    logic [CNT_WIDTH-1:0]        in_cnt1;
    logic [CNT_WIDTH-1:0]        store_cnt;
    occ_t                        occ;
    occ_t                        nfree;
    logic                        dup;
    logic                        accept;
    logic                        alloc;
    assign occupancy_o = occ;
    assign full_o      = occ == occ_t'(DEPTH);
    assign empty_o     = occ == '0;
    assign in_ready_o  = ~full_o & ~dup;
    assign accept      = in_valid_i & in_ready_o;
    assign in_cnt1     = (in_cnt_i == '0) ? CNT_WIDTH'(1) : in_cnt_i;
    always_comb begin
        dup    = 1'b0;
        slot   = '0;
        hit_p  = '0;
        free_e = '0;
        nfree  = '0;
        k      = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) hit_data[p] = '0;
        for (int e = 0; e < DEPTH; e++) begin
            k = '0;
            for (int p = 0; p < NUM_RD_PORTS; p++)
                if (req_valid_i[p] && valid[e] && tag[e] == req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    k           = k + KW'(1);
                    hit_p[p]    = 1'b1;
                    hit_data[p] = data[e];
                end
            free_e[e]   = (k != '0) && (k >= KW'(cnt[e]));
            cnt_next[e] = cnt[e] - CNT_WIDTH'(k);
            nfree       = nfree + occ_t'(free_e[e]);
            dup         = dup | (valid[e] && tag[e] == in_addr_i);
        end
        for (int e = DEPTH-1; e >= 0; e--) if (!valid[e]) slot = IDX_BITS'(e);
    end
`ifdef EU_XBUF_MP_BYPASS_EN
    always_comb begin
        byp = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++)
            byp[p] = accept && req_valid_i[p] && req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == in_addr_i;
    end
`else
    assign byp = '0;
`endif
    // bypass consumers are charged against the count before the entry is stored
    always_comb begin
        bk = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) bk = bk + KW'(byp[p]);
        alloc     = accept && (KW'(in_cnt1) > bk);
        store_cnt = in_cnt1 - CNT_WIDTH'(bk);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid          <= '0;
            occ            <= '0;
            resp_success_o <= '0;
            resp_data_o    <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++)
                if (free_e[e]) valid[e] <= 1'b0;
                else if (valid[e]) cnt[e] <= cnt_next[e];
            if (alloc) begin
                valid[slot] <= 1'b1;
                tag[slot]   <= in_addr_i;
                data[slot]  <= in_data_i;
                cnt[slot]   <= store_cnt;
            end
            occ <= occ + occ_t'(alloc) - nfree;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                resp_success_o[p] <= hit_p[p] | byp[p];
                if (hit_p[p]) resp_data_o[p*DATA_WIDTH +: DATA_WIDTH] <= hit_data[p];
                else if (byp[p]) resp_data_o[p*DATA_WIDTH +: DATA_WIDTH] <= in_data_i;
            end
        end
    end
endmodule

// File: tb/tb_eu_xbuf_mp.sv
// tb_eu_xbuf_mp: randomized and directed checks of eu_xbuf_mp against a tag-keyed map model.
module tb_eu_xbuf_mp;
    localparam int NP = 2, AW = 8, DW = 16, DEPTH = 4;
`ifdef EU_XBUF_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic [AW-1:0] in_addr_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic [1:0] in_cnt_i = '0;
    logic in_valid_i = 1'b0, in_ready_o;
    logic [NP*AW-1:0] req_addr_i = '0;
    logic [NP-1:0] req_valid_i = '0;
    logic [NP*DW-1:0] resp_data_o;
    logic [NP-1:0] resp_success_o;
    logic [2:0] occupancy_o;
    logic full_o, empty_o;
    int errors = 0, checks = 0;
    int mcnt[int];
    logic [DW-1:0] mdata[int];
    logic exp_succ[NP];
    logic [DW-1:0] exp_data[NP];

    eu_xbuf_mp dut (
        .clk(clk), .reset(reset), .in_addr_i(in_addr_i), .in_data_i(in_data_i),
        .in_cnt_i(in_cnt_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .req_addr_i(req_addr_i), .req_valid_i(req_valid_i), .resp_data_o(resp_data_o),
        .resp_success_o(resp_success_o), .occupancy_o(occupancy_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("resp_success[%0d]", p), resp_success_o[p], exp_succ[p]);
            chk($sformatf("resp_data[%0d]", p), resp_data_o[p*DW +: DW], exp_data[p]);
        end
        chk("occupancy", occupancy_o, mcnt.num());
        chk("full", full_o, mcnt.num() == DEPTH);
        chk("empty", empty_o, mcnt.num() == 0);
    endtask

    task automatic cyc(input logic rst, input logic v, input int a, input logic [DW-1:0] d,
                       input int c, input logic [NP-1:0] rv, input int ra0, input int ra1);
        int ra[NP];
        int hits[int];
        bit ready, acc;
        int bk, c1;
        ra[0] = ra0; ra[1] = ra1;
        reset = rst; in_valid_i = v; in_addr_i = AW'(a); in_data_i = d; in_cnt_i = 2'(c);
        req_valid_i = rv; req_addr_i = {AW'(ra1), AW'(ra0)};
        #1;
        ready = mcnt.num() < DEPTH && !mcnt.exists(a);
        chk("in_ready", in_ready_o, ready);
        acc = v && ready;
        bk = 0;
        for (int p = 0; p < NP; p++) begin
            if (rv[p] && mcnt.exists(ra[p])) begin
                exp_succ[p] = 1'b1;
                exp_data[p] = mdata[ra[p]];
                hits[ra[p]] = hits.exists(ra[p]) ? hits[ra[p]] + 1 : 1;
            end else if (BYP && rv[p] && acc && ra[p] == a) begin
                exp_succ[p] = 1'b1;
                exp_data[p] = d;
                bk++;
            end else exp_succ[p] = 1'b0;
        end
        foreach (hits[t]) begin
            mcnt[t] -= hits[t];
            if (mcnt[t] <= 0) mcnt.delete(t);
        end
        c1 = (c == 0) ? 1 : c;
        if (acc && c1 - bk > 0) begin
            mcnt[a] = c1 - bk;
            mdata[a] = d;
        end
        if (rst) begin
            mcnt.delete();
            for (int p = 0; p < NP; p++) begin
                exp_succ[p] = 1'b0;
                exp_data[p] = '0;
            end
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            exp_succ[p] = 1'b0;
            exp_data[p] = '0;
        end
        check_outputs();
        chk("reset empty literal", empty_o, 1'b1);
        // single consumer write then read
        cyc(0, 1, 5, 16'hAB, 1, 2'b00, 0, 0);
        chk("t1 occ after write", occupancy_o, 3'd1);
        cyc(0, 0, 0, 0, 0, 2'b01, 5, 0);
        chk("t1 succ", resp_success_o[0], 1'b1);
        chk("t1 data", resp_data_o[15:0], 16'hAB);
        chk("t1 empty", empty_o, 1'b1);
        // two consumers in the same cycle
        cyc(0, 1, 3, 16'h33, 2, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 2'b11, 3, 3);
        chk("t2 succ", resp_success_o, 2'b11);
        chk("t2 data", resp_data_o, 32'h0033_0033);
        chk("t2 occ", occupancy_o, 3'd0);
        // fill, blocked write, read frees a slot for the next cycle
        for (int i = 1; i <= 4; i++) cyc(0, 1, i, DW'(16'h10 + i), 1, 2'b00, 0, 0);
        chk("t3 full", full_o, 1'b1);
        cyc(0, 1, 7, 16'h17, 1, 2'b01, 2, 0);
        chk("t3 read 2 data", resp_data_o[15:0], 16'h12);
        chk("t3 ready after free", in_ready_o, 1'b1);
        cyc(0, 1, 7, 16'h17, 1, 2'b00, 0, 0);
        chk("t3 full again", occupancy_o, 3'd4);
        // duplicate write, absent read
        cyc(0, 0, 0, 0, 0, 2'b01, 1, 0);
        cyc(0, 1, 6, 16'h16, 1, 2'b00, 0, 0);
        cyc(0, 1, 9, 16'h99, 1, 2'b00, 0, 0);
        in_addr_i = 8'd6; #1;
        chk("t4 dup ready", in_ready_o, 1'b0);
        cyc(0, 1, 6, 16'hEE, 1, 2'b11, 9, 3);
        chk("t4 miss succ", resp_success_o[0], 1'b0);
        chk("t4 miss data held", resp_data_o[15:0], 16'h11);
        chk("t4 port1 hit", resp_data_o[31:16], 16'h13);
        // same-cycle write and request
        cyc(0, 1, 8, 16'h88, 1, 2'b01, 8, 0);
        chk("t5 bypass succ", resp_success_o[0], BYP);
        chk("t5 occ", occupancy_o, BYP ? 3'd3 : 3'd4);
        // reset with outstanding request
        cyc(0, 0, 0, 0, 0, 2'b01, 4, 0);
        cyc(1, 0, 0, 0, 0, 2'b01, 6, 0);
        chk("t6 succ", resp_success_o[0], 1'b0);
        chk("t6 occ", occupancy_o, 3'd0);
        cyc(0, 0, 0, 0, 0, 2'b01, 7, 0);
        chk("t6 old tag miss", resp_success_o[0], 1'b0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(99) == 0, $urandom_range(9) < 6, int'($urandom_range(7)),
                DW'($urandom), int'($urandom_range(3)), NP'($urandom),
                int'($urandom_range(7)), int'($urandom_range(7)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
